// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with mid-bit sampling,
// a one-entry valid/ready output register and error pulses.
// Ports: clk, rstn (sync, active-low), sig (async line, idle 1),
//   data/valid/ready (output handshake), frame_err, overrun (pulses).
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 20_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CW = $clog2(PULSE_WIDTH) + 1;
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] PULSE_RELOAD = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] HALF_RELOAD  = CW'(HALF_PULSE_WIDTH - 1);
  localparam logic [BW-1:0] LAST_BIT     = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    RECOVER, IDLE, START, DATA, STOP
  } state_t;

  state_t state, next_state;

  logic s1, s2, s;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_idx;
  logic [DATA_WIDTH-1:0] shreg;

  logic timed, tick, word_done, stop_bad;

  // Two-flop synchronizer; idle level on reset so no false start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= sig;
      s2 <= s1;
    end
  end

  assign s = s2;

  always_ff @(posedge clk) begin
    if (!rstn) state <= RECOVER;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      RECOVER: if (s) next_state = IDLE;
      IDLE:    if (!s) next_state = START;
      START:   if (tick) next_state = s ? IDLE : DATA;
      DATA:    if (tick && bit_idx == LAST_BIT)
                 next_state = STOP;
      STOP:    if (tick) next_state = s ? IDLE : RECOVER;
      default: next_state = RECOVER;
    endcase
  end

  always_comb begin
    timed     = 1'b0;
    tick      = 1'b0;
    word_done = 1'b0;
    stop_bad  = 1'b0;
    unique case (state)
      START, DATA: begin
        timed = 1'b1;
        tick  = (cnt == '0);
      end
      STOP: begin
        timed     = 1'b1;
        tick      = (cnt == '0);
        word_done = tick && s;
        stop_bad  = tick && !s;
      end
      default: ;
    endcase
  end

  // Outside the timed states the counter sits preloaded so that the
  // start sample lands HALF_PULSE_WIDTH cycles after the falling edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (timed)
        cnt <= (cnt == '0) ? PULSE_RELOAD : cnt - CW'(1);
      else
        cnt <= HALF_RELOAD;
      if (state == DATA && tick) begin
        shreg[bit_idx] <= s;
        bit_idx <= bit_idx + BW'(1);
      end else if (state != DATA) begin
        bit_idx <= '0;
      end
    end
  end

  // A completing word may replace a word consumed in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= word_done && valid && !ready;
      if (word_done && (!valid || ready)) begin
        data  <= shreg;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
